note_bus_synth: RTL

NOTE_BUS_SYNTH -- requirements
Module: note_bus_synth

---
 rtl/note_bus_synth_if.sv | 28 ++
 rtl/note_bus_synth.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/note_bus_synth_if.sv
// Sample and note bus between the chord registers, the synthesiser and the audio sink.
// The master drives notes and sample_ready; the synthesiser (slave) drives the sample side.
interface note_bus_synth_if;
   logic [9:0]  notes;
   logic        sample_ready;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic [3:0]  active_voices;
   logic        overrun;

   modport master (
      output notes,
      output sample_ready,
      input  sample_valid,
      input  sample_data,
      input  active_voices,
      input  overrun
   );

   modport slave (
      input  notes,
      input  sample_ready,
      output sample_valid,
      output sample_data,
      output active_voices,
      output overrun
   );
endinterface

// File: rtl/note_bus_synth.sv
// Ten-voice square-wave chord synthesiser with a valid/ready sample output and sticky overrun.
// Optional macro CHORD_CLICKFREE_EN: voice gates change only at that voice's waveform edges.
module note_bus_synth #(
   parameter int unsigned   SAMPLE_DIV   = 1042,
   parameter int unsigned   AMPLITUDE    = 3000,
   parameter logic [199:0]  HALF_PERIODS = {20'd37922, 20'd42566, 20'd47778, 20'd50619, 20'd56818,
                                            20'd63776, 20'd71586, 20'd75843, 20'd85131, 20'd95556}
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   note_bus_synth_if.slave   bus
);

   localparam int unsigned         TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
   localparam logic signed [19:0]  AMP       = 20'(AMPLITUDE);

   typedef enum logic {
      OUT_EMPTY,
      OUT_FULL
   } out_state_t;

   logic [9:0]          notes_m;
   logic [9:0]          notes_s;
   logic [9:0]          phase;
   logic [9:0]          wrap;
   logic [9:0]          gate;
   logic [3:0]          gate_count;
   logic signed [19:0]  mix_sum;
   logic [15:0]         mix;
   logic [TICK_W-1:0]   tick_cnt;
   logic                tick;
   out_state_t          out_state;
   out_state_t          out_next;
   logic                load_sample;
   logic                drop_sample;
   logic [15:0]         sample_reg;
   logic [3:0]          active_reg;
   logic                overrun_reg;

   // notes comes from another clock domain, so it is resynchronised before any use
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         notes_m <= '0;
         notes_s <= '0;
      end else begin
         notes_m <= bus.notes;
         notes_s <= notes_m;
      end
   end

   // Oscillators free-run regardless of gating so all voices stay phase-coherent from reset
   for (genvar v = 0; v < 10; v++) begin : g_voice
      localparam logic [19:0] LAST = HALF_PERIODS[20*v +: 20] - 20'd1;
      logic [19:0] cnt;
      logic        phase_r;

      assign wrap[v]  = (cnt == LAST);
      assign phase[v] = phase_r;

      always_ff @(posedge CLOCK_50 or negedge resetn) begin
         if (!resetn) begin
            cnt     <= '0;
            phase_r <= 1'b0;
         end else if (wrap[v]) begin
            cnt     <= '0;
            phase_r <= ~phase_r;
         end else begin
            cnt     <= cnt + 20'd1;
         end
      end
   end

   // Gate register; the click-free build only lets a voice switch on its own waveform edge
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         gate <= '0;
      end else begin
`ifdef CHORD_CLICKFREE_EN
         gate <= (wrap & notes_s) | (~wrap & gate);
`else
         gate <= notes_s;
`endif
      end
   end

   // Mix and popcount; the sum fits 16 bits by construction, so plain truncation is safe
   always_comb begin
      mix_sum    = '0;
      gate_count = '0;
      for (int i = 0; i < 10; i++) begin
         if (gate[i]) begin
            mix_sum = phase[i] ? (mix_sum + AMP) : (mix_sum - AMP);
         end
         gate_count = gate_count + {3'b000, gate[i]};
      end
   end

   assign mix = 16'(mix_sum);

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         tick_cnt   <= '0;
         active_reg <= '0;
      end else begin
         tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
         active_reg <= gate_count;
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         out_state <= OUT_EMPTY;
      end else begin
         out_state <= out_next;
      end
   end

   // A tick either refills the output slot or, if the sink is stalled, drops the new mix
   always_comb begin
      out_next    = out_state;
      load_sample = 1'b0;
      drop_sample = 1'b0;
      case (out_state)
         OUT_EMPTY: begin
            if (tick) begin
               load_sample = 1'b1;
               out_next    = OUT_FULL;
            end
         end
         OUT_FULL: begin
            if (tick) begin
               if (bus.sample_ready) begin
                  load_sample = 1'b1;
               end else begin
                  drop_sample = 1'b1;
               end
            end else if (bus.sample_ready) begin
               out_next = OUT_EMPTY;
            end
         end
         default: out_next = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sample_reg  <= '0;
         overrun_reg <= 1'b0;
      end else begin
         if (load_sample) begin
            sample_reg <= mix;
         end
         if (drop_sample) begin
            overrun_reg <= 1'b1;
         end
      end
   end

   assign bus.sample_valid  = (out_state == OUT_FULL);
   assign bus.sample_data   = sample_reg;
   assign bus.active_voices = active_reg;
   assign bus.overrun       = overrun_reg;

endmodule
